// File: rtl/md_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit_pkg : op codes and state encoding for the E-stage md unit    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit : multi-cycle mult/div unit holding HI/LO, with mthi/mtlo    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        HiLoSel,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [31:0]      INT_MIN  = 32'h8000_0000;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;

  logic        is_md, is_mult, mt_write, wb_en;
  logic        res_valid;
  logic [31:0] res_hi, res_lo;

  assign is_mult  = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
  assign is_md    = is_mult || (MDOp == MD_DIV) || (MDOp == MD_DIVU);
  assign Busy     = (state_q == S_RUN);
  assign Start    = is_md && !Req && !Busy && !Reset;
  assign mt_write = ((MDOp == MD_MTHI) || (MDOp == MD_MTLO)) && !Req && !Busy;

  assign HI  = hi_q;
  assign LO  = lo_q;
  assign Out = HiLoSel ? hi_q : lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          cnt_d   = is_mult ? MULT_CNT : DIV_CNT;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          wb_en   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divisor forced to 1 on /0 and on INT_MIN/-1; the latter then yields
  // quotient INT_MIN and remainder 0 directly, and /0 never writes back.
  logic               div_zero, div_ovf;
  logic [31:0]        sdiv_den, udiv_den, uquo, urem;
  logic signed [31:0] squo, srem;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = (a_q == INT_MIN) && (b_q == 32'hFFFF_FFFF);
  assign sdiv_den = (div_zero || div_ovf) ? 32'd1 : b_q;
  assign udiv_den = div_zero ? 32'd1 : b_q;
  assign squo     = $signed(a_q) / $signed(sdiv_den);
  assign srem     = $signed(a_q) % $signed(sdiv_den);
  assign uquo     = a_q / udiv_den;
  assign urem     = a_q % udiv_den;
  assign prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u   = {32'd0, a_q} * {32'd0, b_q};

  always_comb begin
    res_valid = 1'b0;
    res_hi    = hi_q;
    res_lo    = lo_q;
    case (op_q)
      MD_MULT: begin
        res_valid        = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      MD_MULTU: begin
        res_valid        = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      MD_DIV: begin
        res_valid = !div_zero;
        res_lo    = squo;
        res_hi    = srem;
      end
      MD_DIVU: begin
        res_valid = !div_zero;
        res_lo    = uquo;
        res_hi    = urem;
      end
      default: res_valid = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (Start) begin
        op_q <= MDOp;
        a_q  <= A;
        b_q  <= B;
      end
      if (wb_en && res_valid) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (mt_write) begin
        if (MDOp == MD_MTHI) hi_q <= A;
        else                 lo_q <= A;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_md_unit : directed and random checks of md_unit against a model   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_md_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  MDOp = OP_NONE;
  logic        HiLoSel = 1'b0, Req = 1'b0;
  logic        Start, Busy;
  logic [31:0] HI, LO, Out;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .MDOp(MDOp), .HiLoSel(HiLoSel),
    .Req(Req), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Architectural effect of one completed op on HI/LO, in 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      OP_MULT:  begin r = sa * sb; hi_m = r[63:32]; lo_m = r[31:0]; end
      OP_MULTU: begin r = ua * ub; hi_m = r[63:32]; lo_m = r[31:0]; end
      OP_DIV:   if (b != 0) begin q = sa / sb; m = sa % sb; lo_m = q[31:0]; hi_m = m[31:0]; end
      OP_DIVU:  if (b != 0) begin q = ua / ub; m = ua % ub; lo_m = q[31:0]; hi_m = m[31:0]; end
      OP_MTHI:  hi_m = a;
      OP_MTLO:  lo_m = a;
      default:  ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, HI, hi_m);
    check({tag, "_lo"}, LO, lo_m);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    n = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
    MDOp = op; A = a; B = b; Req = 1'b0;
    #1;
    check({tag, "_start"}, Start, 1);
    check({tag, "_busy0"}, Busy, 0);
    step();
    MDOp = OP_NONE; A = $urandom; B = $urandom;
    for (int i = 1; i <= n; i++) begin
      HiLoSel = 1'($urandom);
      #1;
      check({tag, "_busy"}, Busy, 1);
      check({tag, "_out_run"}, Out, HiLoSel ? hi_m : lo_m);
      step();
    end
    model(op, a, b);
    check({tag, "_done"}, Busy, 0);
    check_regs(tag);
  endtask

  task automatic mt_op(input string tag, input logic [3:0] op, input logic [31:0] a);
    MDOp = op; A = a; Req = 1'b0;
    #1;
    check({tag, "_start"}, Start, 0);
    step();
    MDOp = OP_NONE;
    model(op, a, 32'd0);
    check({tag, "_busy"}, Busy, 0);
    check_regs(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    // Reset: Start masked, everything cleared.
    MDOp = OP_MULT; A = $urandom; B = $urandom;
    #1;
    check("rst_start", Start, 0);
    step();
    step();
    check("rst_busy", Busy, 0);
    check_regs("rst");
    Reset = 1'b0; MDOp = OP_NONE;
    step();

    run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult_hi_k", HI, 32'hFFFF_FFFF);
    check("mult_lo_k", LO, 32'hFFFF_FFFE);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_k", HI, 32'h0000_0001);
    check("multu_lo_k", LO, 32'hFFFF_FFFE);
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_k", LO, 32'hFFFF_FFFD);
    check("div_hi_k", HI, 32'hFFFF_FFFF);
    run_op("divu", OP_DIVU, 32'd7, 32'd2);
    check("divu_lo_k", LO, 32'd3);
    check("divu_hi_k", HI, 32'd1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_k", LO, 32'h8000_0000);
    check("div_ovf_hi_k", HI, 32'd0);

    // Divide by zero leaves HI/LO untouched.
    mt_op("mthi", OP_MTHI, 32'h1234);
    mt_op("mtlo", OP_MTLO, 32'h5678);
    run_op("div0", OP_DIV, 32'hCAFE_F00D, 32'd0);
    HiLoSel = 1'b1; #1;
    check("div0_out_hi", Out, 32'h1234);
    HiLoSel = 1'b0; #1;
    check("div0_out_lo", Out, 32'h5678);
    step();

    // Req cancels mult and mtlo.
    MDOp = OP_MULT; A = 32'd3; B = 32'd4; Req = 1'b1;
    #1;
    check("req_start", Start, 0);
    step();
    check("req_busy", Busy, 0);
    check_regs("req_mult");
    MDOp = OP_MTLO; A = 32'hBAD0_BAD0;
    step();
    check_regs("req_mtlo");
    Req = 1'b0; MDOp = OP_NONE;
    step();

    // Reset in the third busy cycle of a div aborts write-back.
    MDOp = OP_DIV; A = 32'd100; B = 32'd7;
    #1;
    check("rdiv_start", Start, 1);
    step();
    MDOp = OP_NONE;
    step();
    step();
    check("rdiv_busy3", Busy, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check("rdiv_busy", Busy, 0);
    check_regs("rdiv_rst");
    repeat (12) step();
    check("rdiv_busy_late", Busy, 0);
    check_regs("rdiv_late");

    // md ops presented during RUN are ignored; second mult accepted at t0+6.
    mt_op("pre_lo", OP_MTLO, 32'h0000_1111);
    MDOp = OP_MULT; A = 32'h0001_0003; B = 32'h0002_0005;
    #1;
    check("ov_start", Start, 1);
    step();
    MDOp = OP_MTLO; A = 32'hDEAD_BEEF;
    #1;
    check("ov_mtlo_start", Start, 0);
    step();
    check("ov_mtlo_ignored", LO, lo_m);
    MDOp = OP_MULT; A = 32'd9; B = 32'hFFFF_FFFD;
    for (int i = 2; i <= 5; i++) begin
      #1;
      check("ov_busy", Busy, 1);
      check("ov_start_run", Start, 0);
      step();
    end
    model(OP_MULT, 32'h0001_0003, 32'h0002_0005);
    check("ov_done", Busy, 0);
    check_regs("ov_first");
    run_op("ov_second", OP_MULT, 32'd9, 32'hFFFF_FFFD);

    // Random ops against the model.
    for (int k = 0; k < 30; k++) begin
      rop = 4'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (rop == OP_MTHI || rop == OP_MTLO) mt_op("rnd_mt", rop, ra);
      else run_op("rnd", rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
